// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: per-GPR pending-write counters and the D-stage stall.
// Optional macro GRF_SCOREBOARD_STATS_EN adds a saturating stall_cycles counter output.
module grf_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int IF_W         = 3
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs,
    input  logic            issue_rs_used,
    input  logic [4:0]      issue_rt,
    input  logic            issue_rt_used,
    input  logic            issue_we,
    input  logic [4:0]      issue_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic            issue_fire,
    output logic [31:0]     busy_vec,
    output logic [IF_W-1:0] inflight,
`ifdef GRF_SCOREBOARD_STATS_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IF_W-1:0]  IF_MAX   = IF_W'(MAX_INFLIGHT);

    logic [31:0][CNT_W-1:0] r_cnt;
    logic [31:0][CNT_W-1:0] w_cnt_nxt;
    logic [IF_W-1:0]        r_inflight;
    logic                   r_err;

    logic [CNT_W-1:0] w_wb_cnt;
    logic [CNT_W-1:0] w_rd_cnt;
    logic             w_wb_hit;
    logic             w_dec;
    logic             w_err_set;
    logic             w_inc;
    logic             w_rd_full;
    logic             w_if_full;
    logic             w_stall;

    // A source is ready when untracked, idle, or its only pending write retires now.
    function automatic logic reg_ready(input logic [4:0] r, input logic [CNT_W-1:0] c,
                                       input logic wv, input logic [4:0] wr);
        reg_ready = (r == 5'd0) || (c == CNT_ZERO) || ((c == CNT_ONE) && wv && (wr == r));
    endfunction

    assign w_wb_cnt  = r_cnt[wb_rd];
    assign w_rd_cnt  = r_cnt[issue_rd];
    assign w_wb_hit  = wb_valid && (wb_rd != 5'd0);
    assign w_dec     = w_wb_hit && (w_wb_cnt != CNT_ZERO);
    assign w_err_set = w_wb_hit && (w_wb_cnt == CNT_ZERO);
    assign w_rd_full = (w_rd_cnt == CNT_MAX) && !(wb_valid && (wb_rd == issue_rd));
    assign w_if_full = (r_inflight == IF_MAX) && !w_dec;

    // Stall evaluation: RAW on either source, or no room to record the new write.
    always_comb begin
        w_stall = 1'b0;
        if (issue_valid) begin
            w_stall = (issue_rs_used && !reg_ready(issue_rs, r_cnt[issue_rs], wb_valid, wb_rd))
                   || (issue_rt_used && !reg_ready(issue_rt, r_cnt[issue_rt], wb_valid, wb_rd))
                   || (issue_we && (issue_rd != 5'd0) && (w_rd_full || w_if_full));
        end else begin
            w_stall = 1'b0;
        end
    end

    assign stall      = w_stall;
    assign issue_fire = issue_valid && !w_stall && !flush;
    assign w_inc      = issue_fire && issue_we && (issue_rd != 5'd0);

    // Next counter values; an issue and retire on the same register cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (flush) begin
            w_cnt_nxt = '0;
        end else begin
            if (w_inc) begin
                w_cnt_nxt[issue_rd] = w_cnt_nxt[issue_rd] + CNT_ONE;
            end else begin
                w_cnt_nxt[issue_rd] = w_cnt_nxt[issue_rd];
            end
            if (w_dec) begin
                w_cnt_nxt[wb_rd] = w_cnt_nxt[wb_rd] - CNT_ONE;
            end else begin
                w_cnt_nxt[wb_rd] = w_cnt_nxt[wb_rd];
            end
        end
        w_cnt_nxt[0] = CNT_ZERO;
    end

    // Scoreboard state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt      <= '0;
            r_inflight <= {IF_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (flush) begin
                r_inflight <= {IF_W{1'b0}};
            end else begin
                r_inflight <= r_inflight + IF_W'(w_inc) - IF_W'(w_dec);
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Busy bits mirror nonzero counters; r0 is never tracked.
    always_comb begin
        busy_vec = 32'h0000_0000;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (r_cnt[i] != CNT_ZERO);
        end
    end

    assign inflight = r_inflight;
    assign err      = r_err;

`ifdef GRF_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;

    // Stalled-issue cycle counter, saturating, survives flush.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cycles <= 32'h0000_0000;
        end else if (issue_valid && w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'h0000_0001;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Register-file hazard controller: tracks in-flight writes to each of the 32 GPRs between issue (D stage) and writeback (W stage).
- Produces the D-stage stall that gates reads of the general register file until pending producers have written back.
- Cooperates with the GRF's same-cycle write-to-read bypass: a register whose last pending write is retiring this cycle is treated as ready.
- Sits beside the GRF in D stage; driven by the decoder (issue side) and W stage (retire side).

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max pending per register = 2^CNT_W-1).
- MAX_INFLIGHT, 4, max total pending writes across all registers; range 1..(2^IF_W-1).
- IF_W, 3, width of the total in-flight counter.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  reset, asynchronous, active-low.
- issue_valid  input  1  D-stage instruction present.
- issue_rs  input  5  source register 1 (GRF A1).
- issue_rs_used  input  1  instruction reads rs.
- issue_rt  input  5  source register 2 (GRF A2).
- issue_rt_used  input  1  instruction reads rt.
- issue_we  input  1  instruction writes a GPR.
- issue_rd  input  5  destination register (future GRF A3).
- wb_valid  input  1  W stage writes GRF this cycle (GRF WE).
- wb_rd  input  5  W-stage destination (GRF A3).
- flush  input  1  kill all in-flight writes (exception/eret).
- stall  output  1  hold D stage; combinational.
- issue_fire  output  1  issue_valid && !stall && !flush.
- busy_vec  output  32  bit r = pending count of r nonzero; bit 0 always 0.
- inflight  output  IF_W  total pending writes.
- err  output  1  sticky: retire with no matching pending write.

Behaviour:
- State: cnt[1..31] (CNT_W bits each), inflight (IF_W bits), err. Register 0 is never tracked: issue_rd==0 or wb_rd==0 has no effect on any counter.
- Reset (async, RESET_N low): all cnt=0, inflight=0, err=0. Outputs: stall=0 when issue_valid=0, busy_vec=0, inflight=0, err=0, issue_fire=0.
- ready(r): true when r==0; true when cnt[r]==0; true when cnt[r]==1 && wb_valid && wb_rd==r (GRF bypass supplies the value). False otherwise.
- stall asserted when issue_valid is high and any of the following holds:
  - issue_rs_used && !ready(issue_rs);
  - issue_rt_used && !ready(issue_rt);
  - issue_we && issue_rd!=0 && cnt[issue_rd]==2^CNT_W-1 && !(wb_valid && wb_rd==issue_rd);
  - issue_we && issue_rd!=0 && inflight==MAX_INFLIGHT && !(wb_valid && wb_rd!=0 && cnt[wb_rd]!=0).
- stall is not asserted by flush; the flush cycle simply produces no fire.
- Per-clock update, no flush:
  - inc = issue_fire && issue_we && issue_rd!=0.
  - dec = wb_valid && wb_rd!=0 && cnt[wb_rd]!=0.
  - cnt[issue_rd] += inc; cnt[wb_rd] -= dec. Same register on both sides nets to no change.
  - inflight += inc - dec.
- wb_valid && wb_rd!=0 && cnt[wb_rd]==0: counters unchanged; err set to 1 and held until reset.
- flush high: all cnt=0 and inflight=0 on the next edge; a same-cycle issue or retire is ignored; err unchanged.
- Latency: an issued write is visible in busy_vec one cycle after issue_fire. A retire releases dependents in the same cycle.
- Counters never wrap: saturation is prevented by the stall conditions.

Optional Feature:
- Macro: GRF_SCOREBOARD_STATS_EN.
- Defined: adds output stall_cycles [31:0], counting cycles with issue_valid && stall. Saturates at 32'hFFFF_FFFF, cleared by reset, not cleared by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, issue_we rd=5 then next cycle rs=5 used -> stall=1, busy_vec[5]=1, inflight=1; wb_valid wb_rd=5 -> stall=0 in that same cycle; next cycle busy_vec=0, inflight=0.
- Issue rd=0 with rs=0 and rt=0 used -> stall=0, issue_fire=1, busy_vec=0, inflight=0.
- Issue rd=7 three times, no retire (CNT_W=2) -> cnt[7]=3; fourth issue to rd=7 -> stall=1; add wb_rd=7 in the same cycle -> fire, cnt[7] stays 3.
- Issue writes to 1,2,3,4 -> inflight=4; issue rd=9 -> stall=1; retire rd=2 in the same cycle -> fire, inflight stays 4.
- With 3 pending writes, flush=1 with issue_valid=1 -> issue_fire=0; next cycle busy_vec=0, inflight=0.
- wb_valid wb_rd=12 with cnt[12]=0 -> err=1 and stays 1; assert RESET_N=0 mid-cycle -> err=0 immediately, without waiting for a clock edge.
